// File: rtl/mojo_com_logic.sv
// Byte-serial register-file bridge: host writes rx_arr and reads tx_arr using
// a command byte (dir + length) followed by an address byte and data.
module mojo_com_logic (
  input  logic          clk,
  input  logic          rst,
  output logic [7:0]    ser_tx_data,
  output logic          ser_new_tx_data,
  input  logic          ser_tx_busy,
  input  logic [7:0]    ser_rx_data,
  input  logic          ser_new_rx_data,
  output logic [2047:0] rx_arr,
  output logic          rx_busy,
  output logic          new_rx,
  input  logic [2047:0] tx_arr,
  output logic          tx_busy,
  output logic [31:0]   cur_addr,
  output logic [31:0]   end_addr,
  output logic [2:0]    cur_state
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ADDR_W  = 9;   // holds start + length up to 255 + 127
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] GET_ADDR  = 3'd1;
  localparam logic [STATE_W-1:0] WRITE     = 3'd2;
  localparam logic [STATE_W-1:0] SEND      = 3'd3;
  localparam logic [STATE_W-1:0] SEND_HOLD = 3'd4;

  logic [STATE_W-1:0] state_q, state_d;
  logic               write_q, write_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_strobe_q, tx_strobe_d;
  logic               new_rx_q, new_rx_d;
  logic               rx_busy_q, rx_busy_d;
  logic               tx_busy_q, tx_busy_d;
  logic               rx_we_c;

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      end_q       <= '0;
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
      new_rx_q    <= 1'b0;
      rx_busy_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      end_q       <= end_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      new_rx_q    <= new_rx_d;
      rx_busy_q   <= rx_busy_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    len_d       = len_q;
    addr_d      = addr_q;
    end_d       = end_q;
    tx_data_d   = tx_data_q;
    tx_strobe_d = 1'b0;
    new_rx_d    = 1'b0;
    rx_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ser_new_rx_data) begin
          write_d = ser_rx_data[7];
          len_d   = ser_rx_data[6:0];
          state_d = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (ser_new_rx_data) begin
          addr_d = ADDR_W'(ser_rx_data);
          end_d  = ADDR_W'(ser_rx_data) + ADDR_W'(len_q);
          if (len_q == '0)
            state_d = IDLE;
          else
            state_d = write_q ? WRITE : SEND;
        end
      end
      WRITE: begin
        if (ser_new_rx_data) begin
          rx_we_c = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          if (addr_q + ADDR_W'(1) == end_q) begin
            state_d  = IDLE;
            new_rx_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (!ser_tx_busy) begin
          tx_data_d   = tx_arr[{addr_q[7:0], 3'b000} +: BYTE_W];
          tx_strobe_d = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          state_d     = SEND_HOLD;
        end
      end
      SEND_HOLD: begin
        // One idle cycle lets the transmitter raise busy before the next check
        state_d = (addr_q == end_q) ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = write_d && ((state_d == GET_ADDR) || (state_d == WRITE));
    tx_busy_d = (!write_d && (state_d == GET_ADDR)) ||
                (state_d == SEND) || (state_d == SEND_HOLD);
  end

  // Host-written register file; byte index wraps modulo 256
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rx_arr <= '0;
    else if (rx_we_c)
      rx_arr[{addr_q[7:0], 3'b000} +: BYTE_W] <= ser_rx_data;
  end

  assign ser_tx_data     = tx_data_q;
  assign ser_new_tx_data = tx_strobe_q;
  assign new_rx          = new_rx_q;
  assign rx_busy         = rx_busy_q;
  assign tx_busy         = tx_busy_q;
  assign cur_addr        = 32'(addr_q);
  assign end_addr        = 32'(end_q);
  assign cur_state       = state_q;

endmodule

// File: tb/tb_mojo_com_logic.sv
// Scoreboard bench for mojo_com_logic: directed scenarios plus randomized
// read/write transactions against a 256-byte array reference model.
module tb_mojo_com_logic;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    ser_tx_data;
  logic          ser_new_tx_data;
  logic          ser_tx_busy = 1'b0;
  logic [7:0]    ser_rx_data;
  logic          ser_new_rx_data;
  logic [2047:0] rx_arr;
  logic          rx_busy;
  logic          new_rx;
  logic [2047:0] tx_arr;
  logic          tx_busy;
  logic [31:0]   cur_addr;
  logic [31:0]   end_addr;
  logic [2:0]    cur_state;

  mojo_com_logic dut (
    .clk(clk), .rst(rst),
    .ser_tx_data(ser_tx_data), .ser_new_tx_data(ser_new_tx_data), .ser_tx_busy(ser_tx_busy),
    .ser_rx_data(ser_rx_data), .ser_new_rx_data(ser_new_rx_data),
    .rx_arr(rx_arr), .rx_busy(rx_busy), .new_rx(new_rx),
    .tx_arr(tx_arr), .tx_busy(tx_busy),
    .cur_addr(cur_addr), .end_addr(end_addr), .cur_state(cur_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_newrx = 0;
  int busy_left = 0;
  int busy_len_next = -1;

  logic [7:0]    model_rx [256];
  logic [7:0]    exp_tx_q[$];
  logic [2047:0] exp_rx_q[$];
  logic [2047:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2047:0] pack_model();
    logic [2047:0] v;
    for (int n = 0; n < 256; n++) v[n*8 +: 8] = model_rx[n];
    return v;
  endfunction

  // Monitor plus transmitter model: pops expectations on each DUT output event
  always @(negedge clk) begin
    if (!rst) begin
      ser_tx_busy = 1'b0;
      busy_left = 0;
    end else begin
      if (ser_new_tx_data) begin
        n_strobe++;
        chk("strobe_while_busy", 64'(ser_tx_busy), 64'd0);
        if (exp_tx_q.size() == 0) chk("unexpected_strobe", 64'd1, 64'd0);
        else chk("tx_byte", 64'(ser_tx_data), 64'(exp_tx_q.pop_front()));
        busy_left = (busy_len_next >= 0) ? busy_len_next : int'($urandom_range(0, 6));
        busy_len_next = -1;
      end
      if (new_rx) begin
        n_newrx++;
        if (exp_rx_q.size() == 0) chk("unexpected_new_rx", 64'd1, 64'd0);
        else begin
          snap = exp_rx_q.pop_front();
          n_cmp++;
          if (rx_arr !== snap) begin
            n_err++;
            for (int i = 0; i < 256; i++)
              if (rx_arr[i*8 +: 8] !== snap[i*8 +: 8]) begin
                $display("FAIL rx_arr byte %0d: got %0h expected %0h", i, rx_arr[i*8 +: 8], snap[i*8 +: 8]);
                break;
              end
          end
        end
      end
      ser_tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  // Caller is positioned just after a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    ser_rx_data = b;
    ser_new_rx_data = 1'b1;
    @(negedge clk);
    ser_new_rx_data = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_rx_q.size() != 0 || exp_tx_q.size() != 0 || tx_busy || rx_busy) && t < 3000) begin
      @(negedge clk); #1; t++;
    end
    chk("idle_timeout", 64'(t >= 3000), 64'd0);
    chk("state_idle", 64'(cur_state), 64'd0);
  endtask

  task automatic do_write(input logic [7:0] addr, input int len, input bq_t d, input bit wait_done);
    for (int i = 0; i < len; i++) model_rx[(int'(addr) + i) % 256] = d[i];
    if (len > 0) exp_rx_q.push_back(pack_model());
    send_byte(8'h80 | 8'(len), $urandom_range(0, 2));
    send_byte(addr, $urandom_range(0, 2));
    for (int i = 0; i < len; i++) send_byte(d[i], (i == len - 1) ? 0 : int'($urandom_range(0, 2)));
    if (wait_done) wait_idle();
  endtask

  task automatic do_read(input logic [7:0] addr, input int len);
    for (int i = 0; i < len; i++) exp_tx_q.push_back(tx_arr[((int'(addr) + i) % 256) * 8 +: 8]);
    send_byte(8'(len), $urandom_range(0, 2));
    send_byte(addr, 0);
    wait_idle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    bq_t d;
    int s0, r0;
    rst = 1'b0;
    ser_rx_data = '0;
    ser_new_rx_data = 1'b0;
    tx_arr = '0;
    foreach (model_rx[i]) model_rx[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'(cur_state), 64'd0);
    chk("rst_rx_arr_nonzero", 64'(rx_arr != '0), 64'd0);
    chk("rst_tx_data", 64'(ser_tx_data), 64'd0);
    chk("rst_strobe", 64'(ser_new_tx_data), 64'd0);
    chk("rst_busy", 64'({rx_busy, tx_busy, new_rx}), 64'd0);
    chk("rst_addr", {cur_addr, end_addr}, 64'd0);
    release_reset();

    // Single-byte write at address 2
    r0 = n_newrx;
    model_rx[2] = 8'h06;
    exp_rx_q.push_back(pack_model());
    send_byte(8'h81, 0); #1;
    chk("rx_busy_after_cmd", 64'(rx_busy), 64'd1);
    send_byte(8'h02, 0); #1;
    chk("rx_busy_after_addr", 64'(rx_busy), 64'd1);
    chk("addr_after_addr", {cur_addr, end_addr}, {32'd2, 32'd3});
    send_byte(8'h06, 0);
    wait_idle();
    chk("byte2", 64'(rx_arr[23:16]), 64'h06);
    chk("new_rx_count_1", 64'(n_newrx - r0), 64'd1);

    // Two-byte write from address 0
    r0 = n_newrx;
    d.delete(); d.push_back(8'hAD); d.push_back(8'hDE);
    do_write(8'h00, 2, d, 1);
    chk("rx_low24", 64'(rx_arr[23:0]), 64'h06DEAD);
    chk("new_rx_count_2", 64'(n_newrx - r0), 64'd1);

    // Single-byte read
    tx_arr = '0;
    tx_arr[31:0] = 32'hDEADBEEF;
    s0 = n_strobe;
    exp_tx_q.push_back(8'hEF);
    send_byte(8'h01, 0); #1;
    chk("tx_busy_get_addr", 64'(tx_busy), 64'd1);
    send_byte(8'h00, 0);
    wait_idle();
    chk("strobes_1", 64'(n_strobe - s0), 64'd1);
    repeat (3) @(negedge clk); #1;
    chk("tx_data_hold", 64'(ser_tx_data), 64'hEF);
    chk("tx_busy_done", 64'(tx_busy), 64'd0);

    // Three-byte read with long busy after first strobe; stray byte ignored
    s0 = n_strobe;
    busy_len_next = 10;
    exp_tx_q.push_back(8'hBE); exp_tx_q.push_back(8'hAD); exp_tx_q.push_back(8'hDE);
    send_byte(8'h03, 0);
    send_byte(8'h01, 3);
    send_byte(8'h85, 0);
    wait_idle();
    chk("strobes_3", 64'(n_strobe - s0), 64'd3);
    chk("rx_busy_after_stray", 64'(rx_busy), 64'd0);

    // Address wrap past 255
    d.delete(); d.push_back(8'h11); d.push_back(8'h22);
    do_write(8'hFF, 2, d, 1);
    chk("wrap_byte255", 64'(rx_arr[2047:2040]), 64'h11);
    chk("wrap_byte0", 64'(rx_arr[7:0]), 64'h22);

    // Command accepted on the new_rx cycle
    d.delete(); d.push_back(8'h77);
    do_write(8'h10, 1, d, 0);
    d.delete(); d.push_back(8'h55);
    do_write(8'h20, 1, d, 1);

    // Reset mid-transaction
    send_byte(8'h81, 1); #1;
    chk("rx_busy_pre_reset", 64'(rx_busy), 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(cur_state), 64'd0);
    chk("mid_rst_rx_arr_nonzero", 64'(rx_arr != '0), 64'd0);
    chk("mid_rst_outs", 64'({rx_busy, tx_busy, new_rx, ser_new_tx_data}), 64'd0);
    chk("mid_rst_tx_data", 64'(ser_tx_data), 64'd0);
    chk("mid_rst_addr", {cur_addr, end_addr}, 64'd0);
    foreach (model_rx[i]) model_rx[i] = '0;
    release_reset();
    s0 = n_strobe;
    do_read(8'h00, 1);
    chk("post_rst_read_strobes", 64'(n_strobe - s0), 64'd1);
    chk("post_rst_rx_arr_nonzero", 64'(rx_arr != '0), 64'd0);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      int len;
      logic [7:0] a;
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d.delete();
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        do_write(a, len, d, $urandom_range(0, 3) != 0);
      end else begin
        for (int w = 0; w < 64; w++) tx_arr[w*32 +: 32] = $urandom;
        s0 = n_strobe;
        do_read(a, len);
        chk("rand_read_strobes", 64'(n_strobe - s0), 64'(len));
      end
    end
    wait_idle();
    chk("final_rx_arr", 64'(rx_arr == pack_model()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mojo_com_logic.md
MOJO_COM_LOGIC -- requirements
Module: mojo_com_logic

Interface
REQ-001 Parameters: none; array size fixed at 2048 bits (256 bytes, byte address 0..255).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ser_tx_data  output  8  byte offered to the serial transmitter.
REQ-005 ser_new_tx_data  output  1  one-cycle strobe qualifying ser_tx_data.
REQ-006 ser_tx_busy  input  1  transmitter busy; no strobe is issued while high.
REQ-007 ser_rx_data  input  8  byte from the serial receiver.
REQ-008 ser_new_rx_data  input  1  one-cycle strobe qualifying ser_rx_data.
REQ-009 rx_arr  output  2048  host-written register file; byte n = rx_arr[8n+7:8n].
REQ-010 rx_busy  output  1  high while a write transaction is in progress.
REQ-011 new_rx  output  1  one-cycle pulse when a write transaction completes.
REQ-012 tx_arr  input  2048  readable register file; byte n = tx_arr[8n+7:8n].
REQ-013 tx_busy  output  1  high while a read transaction is in progress.
REQ-014 cur_addr  output  32  debug: current byte address, zero-extended.
REQ-015 end_addr  output  32  debug: start address + length, zero-extended, no wrap.
REQ-016 cur_state  output  3  debug: state encoding per REQ-018.

Function
REQ-017 Transaction: command byte, address byte, then data. Command bit7 = 1 write / 0 read; bits[6:0] = length L in bytes.
REQ-018 States, encodings: IDLE=0, GET_ADDR=1, WRITE=2, SEND=3, SEND_HOLD=4.
REQ-019 IDLE: on ser_new_rx_data, latch direction and L, go to GET_ADDR.
REQ-020 GET_ADDR: on ser_new_rx_data, cur_addr<=byte, end_addr<=byte+L; go to WRITE (write), SEND (read), or IDLE if L=0 (no strobe, no new_rx).
REQ-021 WRITE: each ser_new_rx_data writes the byte to rx_arr byte cur_addr (visible the following cycle) and increments cur_addr. When the L-th byte is written, go to IDLE and pulse new_rx for exactly one cycle, the cycle after that write edge.
REQ-022 Address arithmetic: byte index = cur_addr mod 256; accesses past 255 wrap to 0.
REQ-023 SEND: when ser_tx_busy=0, drive ser_tx_data = tx_arr byte cur_addr, assert ser_new_tx_data for one cycle, increment cur_addr, go to SEND_HOLD.
REQ-024 SEND_HOLD: wait exactly one cycle, covering transmitter busy rise latency. Then go to IDLE if cur_addr == end_addr, else to SEND.
REQ-025 ser_tx_data holds its last value between strobes.
REQ-026 rx_busy = 1 in GET_ADDR or WRITE of a write transaction. tx_busy = 1 in GET_ADDR of a read transaction, SEND, and SEND_HOLD.
REQ-027 ser_new_rx_data during SEND/SEND_HOLD is ignored. A new command is accepted only in IDLE.
REQ-028 ser_new_rx_data arriving on the new_rx cycle is accepted as the next command.
REQ-029 tx_arr is sampled at strobe time; the block does not snapshot it.
REQ-030 No timeout; a partial transaction waits indefinitely for further bytes.

Reset
REQ-031 rst low, asynchronously: state IDLE, rx_arr=0, ser_tx_data=0, ser_new_tx_data=0, rx_busy=0, tx_busy=0, new_rx=0, cur_addr=0, end_addr=0.
REQ-032 Reset mid-transaction aborts it; already-written rx_arr bytes are cleared to 0.

Verification
REQ-033 Write 0x81, 0x02, 0x06 -> rx_arr[23:16]=0x06. rx_busy high from after 0x81 until the write. new_rx one pulse.
REQ-034 Then write 0x82, 0x00, 0xAD, 0xDE -> rx_arr[23:0]=24'h06DEAD. new_rx pulses once, after 0xDE only.
REQ-035 tx_arr=32'hDEADBEEF; send 0x01, 0x00 -> exactly one strobe, ser_tx_data=0xEF. tx_busy returns to 0.
REQ-036 Send 0x03, 0x01, hold ser_tx_busy high 10 cycles after the first strobe -> bytes BE, AD, DE in order. No strobe while busy high. Three strobes total.
REQ-037 Write 0x82, 0xFF, 0x11, 0x22 -> rx_arr byte 255=0x11, byte 0=0x22 (wrap).
REQ-038 Assert rst low after command byte 0x81 -> all outputs reset. Next 0x01, 0x00 is treated as a fresh read command.
